clock_phase_tracker: RTL and testbench

Upstream controller for the glitch-free clock stretch/invert mux.
- Measures RX line transition timing against a free-running bit-phase counter.
- Votes early/late.
- Issues rate-limited `sel` toggles, each retarding the downstream clock by half a `clk` period.
- Applies whole-cycle advances by skipping the bit-phase counter.

---
 rtl/clock_phase_tracker.sv | 130 +++++++++++++
 tb/tb_clock_phase_tracker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/clock_phase_tracker.sv
// Phase tracker driving a glitch-free clock stretch/invert mux: votes RX edge
// timing against a free-running bit-phase counter and issues rate-limited corrections.
module clock_phase_tracker #(
   parameter int unsigned DIVISOR    = 16,
   parameter int unsigned VOTE_T     = 4,
   parameter int unsigned HOLDOFF    = 8,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       rx,
   output logic                       sel,
   output logic                       sel_changed,
   output logic                       advance,
   output logic [$clog2(DIVISOR)-1:0] phase_cnt,
   output logic                       locked
);

   localparam int unsigned PW = $clog2(DIVISOR);
   localparam int unsigned HW = $clog2(HOLDOFF);
   localparam int unsigned LW = $clog2(LOCK_COUNT + 1);
   localparam logic signed [4:0] VOTE_POS = 5'(VOTE_T);
   localparam logic signed [4:0] VOTE_NEG = -VOTE_POS;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ON_TIME,
      CLS_DEADBAND,
      CLS_LATE,
      CLS_EARLY
   } cls_t;

   logic               s1, s2, s3;
   logic               edge_det;
   cls_t               cls;
   logic signed [4:0]  vote, vote_next;
   logic [HW-1:0]      holdoff, holdoff_next;
   logic [LW-1:0]      lock_cnt, lock_next;
   logic [PW-1:0]      phase_next;
   logic               fire_late, fire_early;

   // Synchronizer keeps running regardless of enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= rx;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 ^ s3;

   always_comb begin
      cls = CLS_NONE;
      if (edge_det) begin
         if (phase_cnt == '0)
            cls = CLS_ON_TIME;
         else if (phase_cnt == PW'(1) || phase_cnt == PW'(DIVISOR - 1))
            cls = CLS_DEADBAND;
         else if (phase_cnt < PW'(DIVISOR / 2))
            cls = CLS_LATE;
         else
            cls = CLS_EARLY;
      end
   end

   assign fire_late  = enable && (holdoff == '0) && (vote == VOTE_POS);
   assign fire_early = enable && (holdoff == '0) && (vote == VOTE_NEG);

   always_comb begin
      vote_next    = vote;
      lock_next    = lock_cnt;
      holdoff_next = holdoff;
      unique case (cls)
         CLS_ON_TIME: if (lock_cnt != LW'(LOCK_COUNT)) lock_next = lock_cnt + LW'(1);
         CLS_LATE: begin
            lock_next = '0;
            if (vote != VOTE_POS) vote_next = vote + 5'sd1;
         end
         CLS_EARLY: begin
            lock_next = '0;
            if (vote != VOTE_NEG) vote_next = vote - 5'sd1;
         end
         default: ;
      endcase
      if (holdoff != '0) holdoff_next = holdoff - HW'(1);
      // A correction discards the same-cycle vote but not the lock update.
      if (fire_late || fire_early) begin
         vote_next    = '0;
         holdoff_next = HW'(HOLDOFF - 1);
      end
      phase_next = phase_cnt + (fire_early ? PW'(2) : PW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel         <= 1'b0;
         sel_changed <= 1'b0;
         advance     <= 1'b0;
         phase_cnt   <= '0;
         locked      <= 1'b0;
         vote        <= '0;
         holdoff     <= '0;
         lock_cnt    <= '0;
      end else if (!enable) begin
         sel_changed <= 1'b0;
         advance     <= 1'b0;
         phase_cnt   <= '0;
         locked      <= 1'b0;
         vote        <= '0;
         holdoff     <= '0;
         lock_cnt    <= '0;
      end else begin
         sel         <= sel ^ fire_late;
         sel_changed <= fire_late;
         advance     <= fire_early;
         phase_cnt   <= phase_next;
         locked      <= (lock_next == LW'(LOCK_COUNT));
         vote        <= vote_next;
         holdoff     <= holdoff_next;
         lock_cnt    <= lock_next;
      end
   end

endmodule

// File: tb/tb_clock_phase_tracker.sv
// Randomized bench for clock_phase_tracker: biased RX edge placement against an
// arithmetic reference model of the tracking rules, plus correction spacing checks.
module tb_clock_phase_tracker;

   localparam int D  = 16;
   localparam int VT = 4;
   localparam int HO = 8;
   localparam int LC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       rx;
   logic       sel, sel_changed, advance, locked;
   logic [3:0] phase_cnt;

   clock_phase_tracker #(
      .DIVISOR(D), .VOTE_T(VT), .HOLDOFF(HO), .LOCK_COUNT(LC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx),
      .sel(sel), .sel_changed(sel_changed), .advance(advance),
      .phase_cnt(phase_cnt), .locked(locked)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state (value after the most recent posedge).
   int m_phase, m_vote, m_hold, m_lock, m_sel, m_selch, m_adv;
   bit samples[$];

   function automatic void model_reset();
      m_phase = 0; m_vote = 0; m_hold = 0; m_lock = 0;
      m_sel = 0; m_selch = 0; m_adv = 0;
      samples = '{1'b1, 1'b1, 1'b1};
   endfunction

   // Advance the model across one posedge given the inputs sampled there.
   function automatic void model_step(input bit en, input bit rx_in);
      // An rx change becomes visible two samples later.
      bit edge_seen = samples[$-1] != samples[$-2];
      int nv;
      bit fl, fe;
      if (!en) begin
         m_phase = 0; m_vote = 0; m_hold = 0; m_lock = 0;
         m_selch = 0; m_adv = 0;
      end else begin
         fl = (m_hold == 0) && (m_vote == VT);
         fe = (m_hold == 0) && (m_vote == -VT);
         nv = m_vote;
         if (edge_seen) begin
            if (m_phase == 0) begin
               if (m_lock < LC) m_lock++;
            end else if (m_phase != 1 && m_phase != D - 1) begin
               m_lock = 0;
               if (m_phase < D / 2) nv = (m_vote + 1 > VT) ? VT : m_vote + 1;
               else                 nv = (m_vote - 1 < -VT) ? -VT : m_vote - 1;
            end
         end
         if (fl || fe) begin
            m_vote = 0;
            m_hold = HO - 1;
         end else begin
            m_vote = nv;
            if (m_hold > 0) m_hold--;
         end
         m_phase = (m_phase + (fe ? 2 : 1)) % D;
         if (fl) m_sel = 1 - m_sel;
         m_selch = fl;
         m_adv   = fe;
      end
      samples.push_back(rx_in);
      void'(samples.pop_front());
   endfunction

   task automatic check_zero_outputs(input string tag);
      check({tag, "_sel"}, int'(sel), 0);
      check({tag, "_selch"}, int'(sel_changed), 0);
      check({tag, "_adv"}, int'(advance), 0);
      check({tag, "_phase"}, int'(phase_cnt), 0);
      check({tag, "_locked"}, int'(locked), 0);
   endtask

   int mode, target, en_off, gap;
   bit toggled;

   initial begin
      rst_n = 1'b0; enable = 1'b0; rx = 1'b1;
      model_reset();
      mode = 0; target = 0; en_off = 0; gap = 1000; toggled = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      enable = 1'b1;

      for (int cyc = 0; cyc < 8000; cyc++) begin
         if (cyc % 96 == 0) mode = $urandom_range(0, 4);

         // Occasional asynchronous reset landing between clock edges.
         if (cyc > 50 && $urandom_range(0, 699) == 0) begin
            #2 rst_n = 1'b0;
            #1 check_zero_outputs("async_rst");
            model_reset();
            gap = 1000;
            @(negedge clk);
            check_zero_outputs("in_rst");
            rst_n = 1'b1;
         end

         if (en_off > 0) begin
            en_off--;
            enable = 1'b0;
            gap = 1000;
         end else begin
            enable = 1'b1;
            if ($urandom_range(0, 299) == 0) en_off = $urandom_range(1, 5);
         end

         if (m_phase == 0) begin
            toggled = 1'b0;
            case (mode)
               0: target = 0;
               1: target = $urandom_range(2, D / 2 - 1);
               2: target = $urandom_range(D / 2, D - 2);
               3: target = ($urandom_range(0, 1) == 0) ? 1 : D - 1;
               default: target = $urandom_range(0, D - 1);
            endcase
         end
         if (!toggled && m_phase == (target + D - 2) % D) begin
            rx = ~rx;
            toggled = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            rx = ~rx;
         end

         model_step(enable, rx);
         @(negedge clk);

         check("sel", int'(sel), m_sel);
         check("sel_changed", int'(sel_changed), m_selch);
         check("advance", int'(advance), m_adv);
         check("phase_cnt", int'(phase_cnt), m_phase);
         check("locked", int'(locked), int'(m_lock == LC));
         if (sel_changed) begin
            check("sel_spacing_ok", int'(gap >= HO), 1);
            gap = 0;
         end else begin
            gap++;
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
